// File: rtl/f_pc_unit_pkg.sv
// f_pc_unit_pkg: next-PC kind codes and fetch address map shared by the fetch stage
package f_pc_unit_pkg;
    typedef enum logic [2:0] {
        npc_seq    = 3'd0,
        npc_branch = 3'd1,
        npc_j      = 3'd2,
        npc_jr     = 3'd3,
        npc_eret   = 3'd4
    } npc_op_e;
    localparam logic [31:0] DEF_PC_RESET   = 32'h0000_3000;
    localparam logic [31:0] DEF_PC_HANDLER = 32'h0000_4180;
    localparam logic [31:0] DEF_IM_LO      = 32'h0000_3000;
    localparam logic [31:0] DEF_IM_HI      = 32'h0000_6ffc;
endpackage

// File: rtl/f_npc_calc.sv
// f_npc_calc: combinational next-PC selection from the D-stage control and operands
module f_npc_calc import f_pc_unit_pkg::*; (
    input  logic [2:0]  NPCOp,
    input  logic        Flag,
    input  logic [31:0] F_PC,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_Imm16,
    input  logic [25:0] D_Index,
    input  logic [31:0] D_RsData,
    input  logic [31:0] EPC,
    output logic [31:0] npc
);
    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic [31:0] j_pc;
    // branch offset is relative to the delay slot; j keeps the region bits of the jump itself
    always_comb begin
        seq_pc = F_PC + 32'd4;
        br_pc  = D_PC + 32'd4 + {{14{D_Imm16[15]}}, D_Imm16, 2'b00};
        j_pc   = {D_PC[31:28], D_Index, 2'b00};
        npc    = (NPCOp == npc_branch && Flag) ? br_pc :
                 (NPCOp == npc_j)              ? j_pc :
                 (NPCOp == npc_jr)             ? D_RsData :
                 (NPCOp == npc_eret)           ? EPC : seq_pc;
    end
endmodule

// File: rtl/f_pc_unit.sv
// f_pc_unit: fetch PC register with exception/stall priority and fetch-side status flags
module f_pc_unit import f_pc_unit_pkg::*; #(
    parameter logic [31:0] PC_RESET   = DEF_PC_RESET,
    parameter logic [31:0] PC_HANDLER = DEF_PC_HANDLER,
    parameter logic [31:0] IM_LO      = DEF_IM_LO,
    parameter logic [31:0] IM_HI      = DEF_IM_HI
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Req,
    input  logic [2:0]  NPCOp,
    input  logic        Flag,
    input  logic [31:0] D_PC,
    input  logic [15:0] D_Imm16,
    input  logic [25:0] D_Index,
    input  logic [31:0] D_RsData,
    input  logic [31:0] EPC,
    output logic [31:0] F_PC,
    output logic        F_BD,
    output logic        F_ExcAdEL,
    output logic        F_Flush
);
    logic [31:0] npc;
    f_npc_calc u_npc (
        .NPCOp   (NPCOp),
        .Flag    (Flag),
        .F_PC    (F_PC),
        .D_PC    (D_PC),
        .D_Imm16 (D_Imm16),
        .D_Index (D_Index),
        .D_RsData(D_RsData),
        .EPC     (EPC),
        .npc     (npc)
    );
    // reset beats exception entry, which beats stall, which beats normal redirect
    always_ff @(posedge clk) begin
        if (reset)
            F_PC <= PC_RESET;
        else if (Req)
            F_PC <= PC_HANDLER;
        else if (!Stall)
            F_PC <= npc;
    end
    // status seen by F/D and CP0: delay-slot marker, fetch address error, eret bubble
    always_comb begin
        F_BD      = (NPCOp == npc_branch) || (NPCOp == npc_j) || (NPCOp == npc_jr);
        F_ExcAdEL = (F_PC[1:0] != 2'b00) || (F_PC < IM_LO) || (F_PC > IM_HI);
        F_Flush   = (NPCOp == npc_eret) && !Stall && !Req;
    end
endmodule

// File: doc/f_pc_unit.md
# f_pc_unit

Fetch-stage program counter and next-PC selection for the five-stage MIPS pipeline. Consumes the D-stage branch-comparator flag and the D-stage decoded jump controls. Holds the F-stage PC register and redirects it on branch, jump, `eret`, exception/interrupt entry and stall. Also produces the fetch-side status the F/D register and CP0 need: delay-slot marker, fetch address exception and `eret` flush.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_3000: PC value after reset.
- `PC_HANDLER`, 32'h0000_4180: exception/interrupt entry address.
- `IM_LO`, 32'h0000_3000: lowest legal fetch address.
- `IM_HI`, 32'h0000_6ffc: highest legal fetch address.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `Stall` in 1: hazard stall from the hazard unit; holds the PC.
- `Req` in 1: CP0 exception/interrupt request, taken this cycle.
- `NPCOp` in 3: D-stage next-PC kind: `npc_seq`, `npc_branch`, `npc_j`, `npc_jr`, `npc_eret`.
- `Flag` in 1: D-stage comparator result; meaningful only when `NPCOp == npc_branch`.
- `D_PC` in 32: PC of the D-stage instruction.
- `D_Imm16` in 16: branch offset field.
- `D_Index` in 26: j/jal index field.
- `D_RsData` in 32: forwarded rs value for jr/jalr.
- `EPC` in 32: current CP0 EPC, already forwarded past any in-flight `mtc0 EPC`.
- `F_PC` out 32: registered fetch PC.
- `F_BD` out 1: the instruction at `F_PC` is a delay slot.
- `F_ExcAdEL` out 1: fetch address error at `F_PC`.
- `F_Flush` out 1: F/D register must load a bubble next edge.

## Operation
Next-PC, all arithmetic modulo 2^32:
- seq: `F_PC + 4`.
- branch: if `Flag`, then `D_PC + 4 + (sign_extend(D_Imm16) << 2)`; otherwise `F_PC + 4`. A not-taken branch still has a delay slot.
- j: `{D_PC[31:28], D_Index, 2'b00}`. The upper bits come from `D_PC`, not from `D_PC+4`.
- jr: `D_RsData`, unmodified. Misalignment is reported later through `F_ExcAdEL`.
- eret: `EPC`. `eret` has no delay slot.
- Any undefined `NPCOp` code is treated as seq.

PC register update priority on each rising edge, highest first:
1. `reset`: `F_PC <= PC_RESET`.
2. `Req`: `F_PC <= PC_HANDLER`. This overrides `Stall` and every `NPCOp`.
3. `Stall`: `F_PC` holds its value.
4. Otherwise: `F_PC <=` next-PC.

Combinational outputs:
- `F_BD = (NPCOp ∈ {branch, j, jr})`. It is independent of `Flag` and of `Stall`. The F/D register latches it together with the instruction.
- `F_ExcAdEL = (F_PC[1:0] != 0) || F_PC < IM_LO || F_PC > IM_HI`. The comparison is unsigned.
- `F_Flush = (NPCOp == npc_eret) && !Stall && !Req`. It discards the sequentially fetched instruction after `eret`.

Boundary conditions:
- `F_PC = 32'hffff_fffc` on seq: the next value wraps to 32'h0000_0000, and `F_ExcAdEL` is 1 there.
- `Req` arriving while a branch is in D: the handler address wins. CP0 owns the BD/EPC bookkeeping.
- `Stall` arriving with a taken branch in D: the redirect is deferred. It takes effect on the first unstalled edge, using the values present at that edge.
- `reset` asserted mid-stream: takes effect on the next edge, overriding `Req` and `Stall`.

## Timing
- `F_PC` is the only state. Its reset value is 32'h0000_3000.
- Combinational output values while `reset` is held: `F_BD` follows `NPCOp` (0 when `NPCOp == npc_seq`), `F_ExcAdEL = 0` (since `F_PC = PC_RESET` is legal), and `F_Flush` follows its equation.
- Every redirect is visible on `F_PC` one cycle after the edge that samples it. There are no extra bubbles beyond the architectural delay slot.
- `F_BD`, `F_ExcAdEL` and `F_Flush` settle within the cycle from the registered `F_PC` and the current D inputs. No output has a combinational path from `clk`.

## Structure
- Add to `header.v`:
  - the `npc_*` codes: seq=0, branch=1, j=2, jr=3, eret=4;
  - `PC_RESET`, `PC_HANDLER`, `IM_LO` and `IM_HI` defines, shared with CP0 and the IM model.
- One sub-module, `f_npc_calc`:
  - purely combinational;
  - maps (`NPCOp`, `Flag`, `F_PC`, `D_PC`, `D_Imm16`, `D_Index`, `D_RsData`, `EPC`) to the next-PC value;
  - `f_pc_unit` wraps it with the PC register, the priority logic and the status outputs.

## Test plan
- Reset, then 3 unstalled cycles with seq: `F_PC` runs 0x3000, 0x3004, 0x3008, 0x300c, and `F_ExcAdEL` stays 0.
- Branch with `D_PC=0x3008`, `Imm16=0xfffe`, `Flag=1`: `F_BD=1`, and next `F_PC=0x3004`. Repeat with `Flag=0`: `F_BD=1`, and `F_PC` advances sequentially.
- j with `D_PC=0x3010`, `Index=0x0000c40`: next `F_PC=0x3100`. jr with `RsData=0x3002`: next `F_PC=0x3002` and `F_ExcAdEL=1`.
- `Stall` held for 2 cycles with a taken branch in D: `F_PC` frozen. On release, the next `F_PC` equals the branch target.
- `eret` with `EPC=0x3020`: `F_Flush=1` and `F_BD=0`, and next `F_PC=0x3020`. `Req=1` together with `Stall=1`: next `F_PC=0x4180`.
- `reset` asserted together with `Req`: `F_PC=0x3000` next cycle.
